// File: rtl/matrix_pkg.sv
// Encodings and helpers shared between the matrix register file and the multiply controller.
package matrix_pkg;

  localparam logic [1:0] TYPE_CELL = 2'b00;
  localparam logic [1:0] TYPE_ROW  = 2'b01;
  localparam logic [1:0] TYPE_COL  = 2'b10;
  localparam logic [1:0] TYPE_INV  = 2'b11;

  localparam logic [1:0] MAT_A   = 2'b00;
  localparam logic [1:0] MAT_B   = 2'b01;
  localparam logic [1:0] MAT_C   = 2'b10;
  localparam logic [1:0] MAT_INV = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATHER = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Low bit of cell slice idx within a row/column bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned cell_width);
    return idx * cell_width;
  endfunction

endpackage

// File: rtl/matrix_col_gather.sv
// Column assembly: walks rows 0..size-1 of a latched column, one cell per cycle,
// into a shadow register; done/column are combinational so the last cell lands with no extra cycle.
module matrix_col_gather
  import matrix_pkg::*;
#(
  parameter int size       = 4,
  parameter int cell_width = 8,
  parameter int width      = cell_width * size,
  parameter int idx_width  = 2
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  start,
  input  logic [idx_width-1:0]  col_idx,
  input  logic [1:0]            mat_sel,
  input  logic [cell_width-1:0] cell_data,
  output logic [idx_width-1:0]  row_idx,
  output logic [idx_width-1:0]  col_sel,
  output logic [1:0]            mat_out,
  output logic                  done,
  output logic [width-1:0]      column
);

  localparam logic [idx_width-1:0] LAST = idx_width'(size - 1);

  logic                 active;
  logic [idx_width-1:0] count;
  logic [idx_width-1:0] col_q;
  logic [1:0]           mat_q;
  logic [width-1:0]     shadow;

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      active <= 1'b0;
      count  <= '0;
      col_q  <= '0;
      mat_q  <= '0;
      shadow <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      col_q  <= col_idx;
      mat_q  <= mat_sel;
    end else if (active) begin
      shadow[slice_lo(32'(count), cell_width) +: cell_width] <= cell_data;
      if (count == LAST) begin
        active <= 1'b0;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign row_idx = count;
  assign col_sel = col_q;
  assign mat_out = mat_q;
  assign done    = active && (count == LAST);

  // Final row is merged straight from storage so the column is complete on the done cycle.
  always_comb begin
    column = shadow;
    column[slice_lo(size - 1, cell_width) +: cell_width] = cell_data;
  end

endmodule

// File: rtl/matrix_reg_file.sv
// Storage for matrices A, B and C behind the multiply controller: cell/row writes,
// cell/row reads with 1-cycle latency and column reads assembled over size cycles.
module matrix_reg_file
  import matrix_pkg::*;
#(
  parameter int size          = 4,
  parameter int cell_width    = 8,
  parameter int address_width = 8,
  parameter int width         = cell_width * size
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic [address_width-1:0] in_address,
  input  logic [1:0]               in_type,
  input  logic [1:0]               in_matrix,
  input  logic                     in_read_en,
  input  logic                     in_write_en,
  input  logic [width-1:0]         in_data,
  output logic [width-1:0]         out_data,
  output logic                     out_data_ready,
  output logic                     out_error
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [address_width-1:0] SIZE_A = address_width'(size);
  localparam logic [address_width:0]   CELLS  = (address_width + 1)'(size * size);

  logic [size-1:0][size-1:0][cell_width-1:0] mem [3];

  logic [IDX_W-1:0] row_i;
  logic [IDX_W-1:0] col_i;
  logic             addr_ok;
  logic             wr_ok;
  logic             rd_ok;
  logic [1:0]       state;

  logic                  g_start;
  logic                  g_done;
  logic [IDX_W-1:0]      g_row;
  logic [IDX_W-1:0]      g_col;
  logic [1:0]            g_mat;
  logic [cell_width-1:0] g_cell;
  logic [width-1:0]      g_column;

  always_comb begin
    row_i   = IDX_W'(in_address / SIZE_A);
    col_i   = IDX_W'(in_address % SIZE_A);
    addr_ok = {1'b0, in_address} < CELLS;
    wr_ok   = addr_ok && (in_matrix != MAT_INV) &&
              ((in_type == TYPE_CELL) || (in_type == TYPE_ROW));
    rd_ok   = addr_ok && (in_matrix != MAT_INV) && (in_type != TYPE_INV);
    g_start = (state == S_IDLE) && in_read_en && rd_ok && (in_type == TYPE_COL);
    g_cell  = mem[g_mat][g_row][g_col];
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      mem[2] <= '0;
    end else if (in_write_en && wr_ok) begin
      if (in_type == TYPE_CELL)
        mem[in_matrix][row_i][col_i] <= in_data[cell_width-1:0];
      else
        mem[in_matrix][row_i] <= in_data;
    end
  end

  // Write errors and read errors share the one-cycle error pulse.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state          <= S_IDLE;
      out_data       <= '0;
      out_data_ready <= 1'b0;
      out_error      <= 1'b0;
    end else begin
      out_error <= in_write_en && !wr_ok;
      case (state)
        S_IDLE: begin
          if (in_read_en) begin
            if (!rd_ok) begin
              out_error      <= 1'b1;
              out_data       <= '0;
              out_data_ready <= 1'b1;
              state          <= S_RESP;
            end else if (in_type == TYPE_COL) begin
              state <= S_GATHER;
            end else begin
              out_data       <= (in_type == TYPE_ROW) ? mem[in_matrix][row_i]
                                                      : width'(mem[in_matrix][row_i][col_i]);
              out_data_ready <= 1'b1;
              state          <= S_RESP;
            end
          end
        end
        S_GATHER: begin
          if (g_done) begin
            out_data       <= g_column;
            out_data_ready <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          out_data_ready <= 1'b0;
          state          <= S_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  matrix_col_gather #(
    .size       (size),
    .cell_width (cell_width),
    .width      (width),
    .idx_width  (IDX_W)
  ) u_col_gather (
    .in_clk    (in_clk),
    .in_reset  (in_reset),
    .start     (g_start),
    .col_idx   (col_i),
    .mat_sel   (in_matrix),
    .cell_data (g_cell),
    .row_idx   (g_row),
    .col_sel   (g_col),
    .mat_out   (g_mat),
    .done      (g_done),
    .column    (g_column)
  );

endmodule

// File: doc/matrix_reg_file.md
Name: matrix_reg_file

Overview:
- Matrix storage serving the square-matrix multiply engine.
- Holds three size x size matrices: A (2'b00), B (2'b01) and C (2'b10).
- Answers row, column and cell read requests, and accepts row and cell writes, over the engine's address/type/matrix/read_en/write_en interface.
- Sits directly behind the multiply controller. It supplies that controller's in_data/in_data_ready and absorbs its C-cell writes.

Parameters:
- size, 4, matrix dimension (rows = columns).
- cell_width, 8, bits per cell.
- address_width, 8, width of the linear cell index; must satisfy 2^address_width >= size*size.
- width, cell_width*size, width of one row or column bus.

Ports:
- in_clk  input  1  clock, rising edge.
- in_reset  input  1  reset, asynchronous, active-low.
- in_address  input  address_width  linear cell index = row*size + col.
- in_type  input  2  00 cell, 01 row, 10 column, 11 invalid.
- in_matrix  input  2  00 A, 01 B, 10 C, 11 invalid.
- in_read_en  input  1  read request, level.
- in_write_en  input  1  write strobe, one cycle per write.
- in_data  input  width  write data; a cell uses bits [cell_width-1:0].
- out_data  output  width  read data; cell i of a row/column sits at bits [i*cell_width +: cell_width].
- out_data_ready  output  1  one-cycle pulse; out_data is valid in that cycle.
- out_error  output  1  one-cycle pulse on an invalid type/matrix or an out-of-range address.

Behaviour:
- Reset (in_reset low, async):
  - All cells of A, B and C cleared to 0.
  - out_data = 0, out_data_ready = 0, out_error = 0, FSM = S_IDLE, gather counter = 0.
  - Reset asserted mid-operation aborts any gather. No response pulse is issued for the aborted read.
- Index decode:
  - row index r = in_address / size; column index c = in_address % size.
  - Row and column reads use r and c respectively. Row writes ignore c.
  - in_address >= size*size makes the request invalid.
- Writes:
  - Performed on any edge where in_write_en = 1, in every FSM state. Independent of the read FSM.
  - type 00: cell (r,c) <= in_data[cell_width-1:0].
  - type 01: row r cell i <= in_data slice i, for all i.
  - type 10 or 11, matrix 11, or out-of-range address: no storage change, out_error pulses next cycle.
  - in_read_en and in_write_en both high: the write is performed and the read is served normally, by the FSM below.
- Read FSM states: S_IDLE, S_GATHER, S_RESP, S_HOLD.
  - S_IDLE, in_read_en = 1, type 00 or 01, valid request: out_data <= cell (zero-extended) or row; out_data_ready <= 1; -> S_RESP. Latency is 1 cycle.
  - S_IDLE, in_read_en = 1, type 10, valid request: latch column c and the matrix select; counter <= 0; -> S_GATHER.
  - S_IDLE, in_read_en = 1, invalid request: out_error <= 1, out_data <= 0, out_data_ready <= 1; -> S_RESP. The requester therefore never hangs.
  - S_GATHER: each cycle copies cell (counter, c) into slice counter of the out_data shadow, then counter++.
    - When counter = size-1, out_data is loaded from the shadow, out_data_ready <= 1, -> S_RESP.
    - Column latency is size+1 cycles from request sample to the pulse.
    - Writes during a gather are visible to any cell not yet copied.
  - S_RESP: out_data_ready <= 0; out_data holds its value; -> S_HOLD.
  - S_HOLD: in_read_en is ignored for exactly one cycle. This absorbs the requester's registered read_en drop. -> S_IDLE.
  - Back-to-back reads: the next request is sampled no earlier than 3 cycles after the prior pulse edge.
- out_error is a one-cycle pulse and is never held.

Decomposition:
- Shared package (matrix_pkg), shared with the multiply controller:
  - TYPE_CELL/ROW/COL encodings.
  - MAT_A/B/C encodings.
  - FSM state localparams.
  - Cell-slice index helper.
- One sub-module, matrix_col_gather:
  - Contains the column counter and the shadow shift/assembly register.
  - Interface: start, column index, matrix select, done pulse, assembled column.

Test Plan (size = 4, cell_width = 8):
1. Reset, then row read A row 2 (address 8) -> out_data = 0, out_data_ready pulses exactly 1 cycle after the request edge, out_error = 0.
2. Row-write A row 1 = 0x04030201, then cell read address 6 -> out_data = 0x00000003.
3. Cell-write B cells (r,1) = r+0x10 for r = 0..3, then column read address 1 -> pulse 5 cycles after the request, out_data = 0x13121110.
4. During the step 3 gather, write B(3,1) = 0xAA on gather cycle 1 -> returned column = 0xAA121110. Repeat the write on the response cycle -> the column is unaffected.
5. Read with matrix = 11, and separately with address = 16 -> out_error and out_data_ready pulse together, out_data = 0, storage unchanged.
6. Hold in_read_en high continuously for 10 cycles on row reads -> pulses exactly every 3 cycles. Drive in_reset low mid-gather -> no pulse, all outputs 0, A/B/C read back 0 after release.
